// File: rtl/frame_phase_sequencer_pkg.sv
// Shared encodings and defaults for the frame phase sequencer and its neighbours.
package frame_phase_sequencer_pkg;

  localparam int unsigned DefNumSlots    = 16;
  localparam int unsigned DefSlotW       = 4;
  localparam int unsigned DefScanTimeout = 64;
  localparam int unsigned DefCntW        = 16;

  localparam int unsigned StateW = 7;

  typedef logic [StateW-1:0] state_t;

  localparam state_t IDLE   = 7'b000_0001;
  localparam state_t SCAN   = 7'b000_0010;
  localparam state_t ACK    = 7'b000_0100;
  localparam state_t MOVE   = 7'b000_1000;
  localparam state_t CALC   = 7'b001_0000;
  localparam state_t APPLY  = 7'b010_0000;
  localparam state_t FINISH = 7'b100_0000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones; clr has priority over inc.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] count
);

  localparam logic [Width-1:0] Max = '1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != Max)) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/frame_phase_sequencer.sv
// Per-frame scheduler: front scan handshake, move, per-slot damage calc, damage apply.
module frame_phase_sequencer
  import frame_phase_sequencer_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = DefNumSlots,
  parameter int unsigned SLOT_W       = DefSlotW,
  parameter int unsigned SCAN_TIMEOUT = DefScanTimeout,
  parameter int unsigned CNT_W        = DefCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gameSCEN,
  input  logic              enable,
  input  logic              front_done,
  output logic              front_start,
  output logic              front_ack,
  output logic              moveSCEN,
  output logic              damageCalcSCEN,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              damageSCEN,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              scan_err,
  output logic [7:0]        overrun_cnt,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned      TmoW     = $clog2(SCAN_TIMEOUT + 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(SCAN_TIMEOUT - 1);
  localparam logic [SLOT_W-1:0] SlotLast = SLOT_W'(NUM_SLOTS - 1);

  state_t              stateQ, stateD;
  logic [SLOT_W-1:0]   slotQ, slotD;
  logic [CNT_W-1:0]    frameCntQ;
  logic                scanErrQ;
  logic [TmoW-1:0]     tmoCnt;
  logic                scanTimeout;

  assign scanTimeout = (stateQ == SCAN) && !front_done && (tmoCnt == TmoLast);

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:   if (gameSCEN && enable) stateD = SCAN;
      SCAN: begin
        if (front_done)       stateD = ACK;
        else if (scanTimeout) stateD = IDLE;
      end
      ACK:    stateD = MOVE;
      MOVE:   stateD = CALC;
      CALC:   if (slotQ == SlotLast) stateD = APPLY;
      APPLY:  stateD = FINISH;
      FINISH: stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    slotD = '0;
    if ((stateQ == CALC) && (slotQ != SlotLast)) slotD = slotQ + SLOT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= IDLE;
      slotQ     <= '0;
      frameCntQ <= '0;
      scanErrQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      slotQ  <= slotD;
      if (stateQ == FINISH) frameCntQ <= frameCntQ + CNT_W'(1);
      if (scanTimeout)      scanErrQ  <= 1'b1;
    end
  end

  // Held at zero outside SCAN so every scan starts counting from zero.
  sat_counter #(
    .Width(TmoW)
  ) uScanTmo (
    .clk  (clk),
    .rst  (rst),
    .clr  (stateQ != SCAN),
    .inc  (stateQ == SCAN),
    .count(tmoCnt)
  );

  // A tick with enable low is not a tick at all, so it cannot overrun.
  sat_counter #(
    .Width(8)
  ) uOverrun (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .inc  (gameSCEN && enable && frame_busy),
    .count(overrun_cnt)
  );

  assign front_start    = (stateQ == SCAN);
  assign front_ack      = (stateQ == ACK);
  assign moveSCEN       = (stateQ == MOVE);
  assign damageCalcSCEN = (stateQ == CALC);
  assign damageSCEN     = (stateQ == APPLY);
  assign frame_done     = (stateQ == FINISH);
  assign frame_busy     = (stateQ != IDLE);
  assign slot_idx       = slotQ;
  assign frame_cnt      = frameCntQ;
  assign scan_err       = scanErrQ;

endmodule

// File: tb/tb_frame_phase_sequencer.sv
// Randomized bench for frame_phase_sequencer against a phase-arithmetic reference model.
module tb_frame_phase_sequencer;

  localparam int NS  = 16;
  localparam int TMO = 64;

  logic        clk, rst, gameSCEN, enable, front_done;
  logic        front_start, front_ack, moveSCEN, damageCalcSCEN, damageSCEN;
  logic        frame_busy, frame_done, scan_err;
  logic [3:0]  slot_idx;
  logic [7:0]  overrun_cnt;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int expOverrun = 0;
  int expFrames = 0;
  bit expScanErr = 0;
  int donePulses = 0;

  frame_phase_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .gameSCEN      (gameSCEN),
    .enable        (enable),
    .front_done    (front_done),
    .front_start   (front_start),
    .front_ack     (front_ack),
    .moveSCEN      (moveSCEN),
    .damageCalcSCEN(damageCalcSCEN),
    .slot_idx      (slot_idx),
    .damageSCEN    (damageSCEN),
    .frame_busy    (frame_busy),
    .frame_done    (frame_done),
    .scan_err      (scan_err),
    .overrun_cnt   (overrun_cnt),
    .frame_cnt     (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {front_start, front_ack, moveSCEN, damageCalcSCEN, damageSCEN, frame_done}
  // in cycle i after tick acceptance, front_done first seen in SCAN cycle d.
  function automatic logic [5:0] exp_strobes(input int i, input int d);
    if (d > TMO) return (i <= TMO) ? 6'b100000 : 6'b000000;
    if (i <= d)           return 6'b100000;
    if (i == d + 1)       return 6'b010000;
    if (i == d + 2)       return 6'b001000;
    if (i <= d + 2 + NS)  return 6'b000100;
    if (i == d + 3 + NS)  return 6'b000010;
    if (i == d + 4 + NS)  return 6'b000001;
    return 6'b000000;
  endfunction

  function automatic int frame_len(input int d);
    return (d <= TMO) ? d + 4 + NS : TMO;
  endfunction

  // Runs one frame from idle; d > TMO means front_done never arrives.
  task automatic run_frame(input int d, input int tickPct, input bit lastTick);
    int         len;
    logic [5:0] exp, got;
    logic [3:0] expSlot;
    bit         tick;
    len = frame_len(d);
    enable = 1'b1; gameSCEN = 1'b1; front_done = 1'b0;
    @(negedge clk);
    gameSCEN = 1'b0;
    for (int i = 1; i <= len; i++) begin
      got = {front_start, front_ack, moveSCEN, damageCalcSCEN, damageSCEN, frame_done};
      exp = exp_strobes(i, d);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL strobes d=%0d cyc=%0d got=%b required=%b", d, i, got, exp);
      end
      checks++;
      if (!$onehot0(got)) begin
        errors++;
        $display("FAIL exclusivity d=%0d cyc=%0d got=%b required=at most one", d, i, got);
      end
      checks++;
      if (frame_busy !== 1'b1) begin
        errors++;
        $display("FAIL busy d=%0d cyc=%0d got=%b required=1", d, i, frame_busy);
      end
      if (exp == 6'b000100) begin
        expSlot = 4'(i - d - 3);
        checks++;
        if (slot_idx !== expSlot) begin
          errors++;
          $display("FAIL slot d=%0d cyc=%0d got=%0d required=%0d", d, i, slot_idx, expSlot);
        end
      end
      if (frame_done === 1'b1) donePulses++;
      tick = ($urandom_range(99) < tickPct) || (lastTick && i == len);
      gameSCEN = tick;
      enable = tick ? 1'b1 : ($urandom_range(3) != 0);
      if (tick && expOverrun < 255) expOverrun++;
      front_done = (i == d);
      @(negedge clk);
    end
    gameSCEN = 1'b0; front_done = 1'b0; enable = 1'b1;
    if (d <= TMO) expFrames = (expFrames + 1) % 65536;
    else expScanErr = 1'b1;
    checks++;
    if (frame_busy !== 1'b0 || {front_start, front_ack, moveSCEN, damageCalcSCEN,
                                damageSCEN, frame_done} !== 6'b0) begin
      errors++;
      $display("FAIL end_idle d=%0d busy=%b front_start=%b required=idle", d, frame_busy,
               front_start);
    end
    checks++;
    if (frame_cnt !== 16'(expFrames)) begin
      errors++;
      $display("FAIL frame_cnt d=%0d got=%0d required=%0d", d, frame_cnt, expFrames);
    end
    checks++;
    if (scan_err !== expScanErr) begin
      errors++;
      $display("FAIL scan_err d=%0d got=%b required=%b", d, scan_err, expScanErr);
    end
    checks++;
    if (overrun_cnt !== 8'(expOverrun)) begin
      errors++;
      $display("FAIL overrun d=%0d got=%0d required=%0d", d, overrun_cnt, expOverrun);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; gameSCEN = 1'b0; enable = 1'b0; front_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({front_start, front_ack, moveSCEN, damageCalcSCEN, damageSCEN, frame_done,
         frame_busy, scan_err} !== 8'b0 || slot_idx !== 4'd0 || overrun_cnt !== 8'd0 ||
        frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b slot=%0d ovr=%0d fcnt=%0d required=all zero",
               frame_busy, slot_idx, overrun_cnt, frame_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy=%b required=0", frame_busy);
    end
  endtask

  task automatic test_basic_frame();
    repeat (8) @(negedge clk);
    run_frame(18, 0, 1'b0);
  endtask

  task automatic test_enable_gate();
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      gameSCEN = (i % 3 == 0) ? 1'b1 : 1'($urandom_range(1));
      @(negedge clk);
      checks++;
      if (frame_busy !== 1'b0 || {front_start, front_ack, moveSCEN, damageCalcSCEN,
                                  damageSCEN, frame_done} !== 6'b0) begin
        errors++;
        $display("FAIL enable_gate cyc=%0d busy=%b front_start=%b required=0", i, frame_busy,
                 front_start);
      end
    end
    gameSCEN = 1'b0; enable = 1'b1;
    @(negedge clk);
    checks++;
    if (overrun_cnt !== 8'(expOverrun)) begin
      errors++;
      $display("FAIL enable_gate_overrun got=%0d required=%0d", overrun_cnt, expOverrun);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(3, 0, 1'b1);
    run_frame(3, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_frame(1000, 0, 1'b0);
    run_frame(5, 0, 1'b0);
    checks++;
    if (scan_err !== 1'b1) begin
      errors++;
      $display("FAIL scan_err_sticky got=%b required=1", scan_err);
    end
  endtask

  task automatic test_overrun();
    for (int f = 0; f < 8; f++) run_frame(18, 100, 1'b0);
    checks++;
    if (overrun_cnt !== 8'd255) begin
      errors++;
      $display("FAIL overrun_saturate got=%0d required=255", overrun_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int d;
    d = 3;
    enable = 1'b1; gameSCEN = 1'b1; front_done = 1'b0;
    @(negedge clk);
    gameSCEN = 1'b0;
    for (int i = 1; i < d + 10; i++) begin
      front_done = (i == d);
      @(negedge clk);
    end
    front_done = 1'b0;
    checks++;
    if (slot_idx !== 4'd7 || damageCalcSCEN !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre slot=%0d calc=%b required=7,1", slot_idx, damageCalcSCEN);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({front_start, front_ack, moveSCEN, damageCalcSCEN, damageSCEN, frame_done,
         frame_busy, scan_err} !== 8'b0 || slot_idx !== 4'd0 || overrun_cnt !== 8'd0 ||
        frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid busy=%b slot=%0d ovr=%0d fcnt=%0d serr=%b required=all zero",
               frame_busy, slot_idx, overrun_cnt, frame_cnt, scan_err);
    end
    rst = 1'b0;
    expOverrun = 0; expFrames = 0; expScanErr = 1'b0; donePulses = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int d, pct, gap;
    for (int f = 0; f < 1000; f++) begin
      d   = ($urandom_range(49) == 0) ? 1000 : int'($urandom_range(30, 1));
      pct = ($urandom_range(3) == 0) ? 20 : 0;
      run_frame(d, pct, ($urandom_range(7) == 0));
      gap = $urandom_range(2);
      for (int g = 0; g < gap; g++) begin
        enable = 1'b0;
        gameSCEN = 1'($urandom_range(1));
        @(negedge clk);
      end
      gameSCEN = 1'b0; enable = 1'b1;
    end
    checks++;
    if (frame_cnt !== 16'(donePulses) || frame_cnt !== 16'(expFrames)) begin
      errors++;
      $display("FAIL random_frame_count got=%0d pulses=%0d required=%0d", frame_cnt,
               donePulses, expFrames);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_enable_gate();
    test_back_to_back();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_phase_sequencer.md
Name: frame_phase_sequencer

Overview:
Per-frame scheduler for the battle engine. On each gameSCEN tick it runs one frame in a fixed order:
- Start/Ack handshake with the front-finder core (friendly/enemy front scan).
- One moveSCEN pulse.
- A damage-calc sweep of all unit slots.
- One damageSCEN pulse.

It sits between the frame-tick generator and the unit datapaths. It guarantees that phases never overlap and that dropped ticks are counted.

Parameters:
NUM_SLOTS, 16, unit slots swept in the damage-calc phase (power of 2, ≥2)
SLOT_W, 4, width of slot_idx; log2(NUM_SLOTS)
SCAN_TIMEOUT, 64, max cycles in SCAN waiting for front_done before abort
CNT_W, 16, width of frame_cnt

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
gameSCEN  in  1  one-cycle frame tick
enable  in  1  game running; ticks ignored when low
front_done  in  1  Done level from the front-finder core
front_start  out  1  Start level to the front-finder core
front_ack  out  1  Ack pulse to the front-finder core
moveSCEN  out  1  one-cycle move enable
damageCalcSCEN  out  1  per-slot damage-calc enable
slot_idx  out  SLOT_W  slot being evaluated while damageCalcSCEN=1
damageSCEN  out  1  one-cycle damage-apply enable
frame_busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at frame end
scan_err  out  1  sticky; set on SCAN timeout
overrun_cnt  out  8  saturating count of dropped ticks
frame_cnt  out  CNT_W  completed frames, wraps

Behaviour:
- All outputs are Moore-decoded from a registered one-hot state plus registers.
- Reset values: state=IDLE; every strobe=0; slot_idx=0; scan_err=0; overrun_cnt=0; frame_cnt=0; timeout counter=0.
- rst asserted mid-frame: the frame is abandoned at the next edge and all strobes go low, front_start included.
- States and transitions:
  - IDLE: if gameSCEN & enable → SCAN, timeout counter cleared. Otherwise a tick is ignored and not counted as an overrun.
  - SCAN: front_start=1.
    - If front_done=1 → ACK.
    - Else if timeout counter = SCAN_TIMEOUT-1 → IDLE, scan_err←1, no further phases, frame_cnt unchanged.
    - Else the counter increments.
  - ACK: front_ack=1 for exactly 1 cycle, front_start=0 → MOVE.
  - MOVE: moveSCEN=1 for 1 cycle → CALC, slot_idx←0.
  - CALC: damageCalcSCEN=1 every cycle with slot_idx=0..NUM_SLOTS-1 in order, one slot per cycle. At slot_idx=NUM_SLOTS-1 → APPLY, slot_idx←0.
  - APPLY: damageSCEN=1 for 1 cycle → FINISH.
  - FINISH: frame_done=1 for 1 cycle, frame_cnt+1 (wraps at 2^CNT_W) → IDLE.
- Latency and frame length:
  - gameSCEN at edge N puts front_start high from cycle N+1.
  - If front_done is first seen D cycles after SCAN entry (D≥1), frame length = D + 4 + NUM_SLOTS cycles.
  - With D=18 and NUM_SLOTS=16 that is 38 cycles.
- Overrun: gameSCEN=1 while frame_busy=1 → overrun_cnt+1, saturating at 255. The tick is dropped; the current frame is unaffected.
- Back-to-back frames: gameSCEN in the same cycle FINISH→IDLE is an overrun. The first accepted tick is from IDLE.
- enable deasserted mid-frame: the frame runs to completion. Only new ticks are gated.
- Exclusivity: at most one of front_start, front_ack, moveSCEN, damageCalcSCEN, damageSCEN, frame_done is high in any cycle.
- scan_err is cleared only by rst.
- Illegal or non-one-hot state → IDLE next cycle, strobes low.

Decomposition:
- Shared package holds:
  - State encodings IDLE, SCAN, ACK, MOVE, CALC, APPLY, FINISH (one-hot, 7 bits).
  - NUM_SLOTS/SLOT_W defaults, shared with the front finder and unit arrays.
  - Default SCAN_TIMEOUT.
- One natural sub-module: sat_counter (parameterised width, increment, saturate). Used for overrun_cnt. The scan timeout counter may reuse it.

Test Plan:
- Reset, then gameSCEN at cycle 10 with enable=1 and front_done at SCAN cycle 18 → front_start high for cycles 11–28, front_ack at 29, moveSCEN at 30, damageCalcSCEN 31–46 with slot_idx 0..15, damageSCEN at 47, frame_done at 48, frame_cnt=1.
- enable=0 with gameSCEN pulses → no strobes, overrun_cnt=0, frame_busy=0.
- Extra gameSCEN during CALC, and 300 extra ticks across long frames → overrun_cnt counts up and saturates at 255. Slot sequence is unaltered.
- front_done held low → IDLE after exactly 64 SCAN cycles, scan_err=1, no moveSCEN, frame_cnt unchanged. The next tick starts a normal frame with scan_err still 1.
- rst asserted at slot_idx=7 → next cycle all strobes 0, slot_idx=0, counters 0, state IDLE.
- Random front_done delays over 1000 frames → the exclusivity and phase-order assertions hold, and frame_cnt equals the number of frame_done pulses.
